// File: rtl/adc_sample_reader_if.sv
// Output sample handshake between adc_sample_reader and its consumer.
interface adc_sample_reader_if #(
  parameter int unsigned DATA_BITS = 12
);
  logic [DATA_BITS-1:0] sample;
  logic                 sample_valid;
  logic                 sample_ready;

  modport master (
    output sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/adc_sample_reader.sv
// Serial ADC frame reader: runs a quiet gap, clocks out one frame on
// adc_sclk, checks the lead bits and presents the sample on a
// valid/ready handshake with sticky overrun and format-error flags.
module adc_sample_reader #(
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned FRAME_BITS   = 16,
  parameter int unsigned LEAD_BITS    = 4,
  parameter int unsigned DATA_BITS    = 12,
  parameter int unsigned QUIET_CYCLES = 4
) (
  input  logic                       pin_clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       start,
  output logic                       adc_cs_n,
  output logic                       adc_sclk,
  input  logic                       adc_so,
  adc_sample_reader_if.master        smp,
  output logic                       overrun,
  output logic                       format_err,
  input  logic                       clear_flags
);

  localparam int unsigned BW = $clog2(FRAME_BITS + 1);
  localparam int unsigned QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_QUIET = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] DATA_LO    = BW'(LEAD_BITS);
  localparam logic [BW-1:0] DATA_HI    = BW'(LEAD_BITS + DATA_BITS);
  localparam logic [7:0]    DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'((QUIET_CYCLES > 0) ? QUIET_CYCLES - 1 : 0);

  logic [1:0]           state;
  logic [7:0]           div_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [QW-1:0]        q_cnt;
  logic [DATA_BITS-1:0] shreg;

  logic sclk_tick;
  logic sclk_rise;
  logic lead_hit;
  logic data_bit;
  logic load;
  logic drop;

  // Phase-end strobes and capture qualifiers derived from the sequencer state
  always_comb begin
    sclk_tick = (state == S_SHIFT) && (div_cnt == DIV_LAST);
    sclk_rise = sclk_tick && !adc_sclk;
    lead_hit  = sclk_rise && adc_so && (bit_cnt < DATA_LO);
    data_bit  = sclk_rise && (bit_cnt >= DATA_LO) && (bit_cnt < DATA_HI);
    load      = (state == S_DONE) && (!smp.sample_valid || smp.sample_ready);
    drop      = (state == S_DONE) && !load;
  end

  // Frame sequencer: quiet gap, SCLK generation, frame end and restart
  always_ff @(posedge pin_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      q_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b1;
          if (enable || start) begin
            state <= S_QUIET;
            q_cnt <= '0;
          end
        end
        S_QUIET: begin
          if (q_cnt >= QUIET_LAST) begin
            state    <= S_SHIFT;
            adc_cs_n <= 1'b0;
            adc_sclk <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
          end else begin
            q_cnt <= q_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (sclk_tick) begin
            div_cnt <= '0;
            if (!adc_sclk) begin
              adc_sclk <= 1'b1;
            end else if (bit_cnt == LAST_BIT) begin
              // SCLK is already high, so it simply stays at its idle level
              adc_cs_n <= 1'b1;
              state    <= S_DONE;
            end else begin
              adc_sclk <= 1'b0;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state <= enable ? S_QUIET : S_IDLE;
          q_cnt <= '0;
        end
      endcase
    end
  end

  // Data bits shift in MSB first; lead and trailing bits never enter
  always_ff @(posedge pin_clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
    end else if (data_bit) begin
      shreg <= DATA_BITS'({shreg, adc_so});
    end
  end

  // Output handshake: a load in DONE takes priority over the consume clear
  always_ff @(posedge pin_clk or negedge reset_n) begin
    if (!reset_n) begin
      smp.sample       <= '0;
      smp.sample_valid <= 1'b0;
    end else if (load) begin
      smp.sample       <= shreg;
      smp.sample_valid <= 1'b1;
    end else if (smp.sample_valid && smp.sample_ready) begin
      smp.sample_valid <= 1'b0;
    end
  end

  // Sticky flags; a set in the same cycle as clear_flags wins
  always_ff @(posedge pin_clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun    <= 1'b0;
      format_err <= 1'b0;
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_flags) begin
        overrun <= 1'b0;
      end
      if (lead_hit) begin
        format_err <= 1'b1;
      end else if (clear_flags) begin
        format_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_reader.sv
// Bench for adc_sample_reader: one default instance plus one with CLK_DIV=3,
// each fed by a behavioural ADC that shifts a table word out MSB first.
module tb_adc_sample_reader;

  localparam int unsigned FB = 16;
  localparam int unsigned LB = 4;
  localparam int unsigned DB = 12;
  localparam int unsigned QC = 4;

  logic pin_clk = 1'b0;
  always #5 pin_clk = ~pin_clk;

  logic reset_n, enable, start, clear_flags, start3;
  logic cs0, sclk0, so0, ovr0, fe0;
  logic cs1, sclk1, so1, ovr1, fe1;

  adc_sample_reader_if #(.DATA_BITS(DB)) if0 ();
  adc_sample_reader_if #(.DATA_BITS(DB)) if1 ();

  adc_sample_reader #(.CLK_DIV(1), .FRAME_BITS(FB), .LEAD_BITS(LB),
                      .DATA_BITS(DB), .QUIET_CYCLES(QC)) dut (
    .pin_clk(pin_clk), .reset_n(reset_n), .enable(enable), .start(start),
    .adc_cs_n(cs0), .adc_sclk(sclk0), .adc_so(so0), .smp(if0.master),
    .overrun(ovr0), .format_err(fe0), .clear_flags(clear_flags));

  adc_sample_reader #(.CLK_DIV(3), .FRAME_BITS(FB), .LEAD_BITS(LB),
                      .DATA_BITS(DB), .QUIET_CYCLES(QC)) dut3 (
    .pin_clk(pin_clk), .reset_n(reset_n), .enable(1'b0), .start(start3),
    .adc_cs_n(cs1), .adc_sclk(sclk1), .adc_so(so1), .smp(if1.master),
    .overrun(ovr1), .format_err(fe1), .clear_flags(clear_flags));

  // ADC models: frame n shifts out word_tab[n % 64], bit k after k SCLK rises
  logic [15:0] word_tab0 [0:63];
  logic [15:0] word_tab1 [0:63];
  logic [15:0] word0 = '0, word1 = '0;
  int rise0 = 0, rise1 = 0, base0 = 0, base1 = 0;
  int starts0 = 0, starts1 = 0, frames0 = 0;

  always @(posedge sclk0) if (!cs0) rise0++;
  always @(posedge sclk1) if (!cs1) rise1++;
  always @(negedge cs0) begin base0 = rise0; word0 = word_tab0[starts0 % 64]; starts0++; end
  always @(negedge cs1) begin base1 = rise1; word1 = word_tab1[starts1 % 64]; starts1++; end
  always @(posedge cs0) if (reset_n) frames0++;

  always_comb begin
    int d0, d1;
    d0 = rise0 - base0;
    d1 = rise1 - base1;
    so0 = (d0 >= 0 && d0 < 16) ? word0[4'(15 - d0)] : 1'b0;
    so1 = (d1 >= 0 && d1 < 16) ? word1[4'(15 - d1)] : 1'b0;
  end

  int checks = 0;
  int errors = 0;

  function automatic logic [DB-1:0] exp_sample(input logic [15:0] w);
    return DB'(w >> (FB - LB - DB));
  endfunction

  function automatic logic exp_fmt(input logic [15:0] w);
    return (w >> (FB - LB)) != 0;
  endfunction

  task automatic pulse_start0();
    start = 1'b1;
    @(posedge pin_clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(posedge pin_clk); #1;
    clear_flags = 1'b0;
  endtask

  // Counts quiet-phase and chip-select-low cycles of dut; ends just after cs rises
  task automatic measure_frame0(output int qc, output int lc);
    qc = 0;
    lc = 0;
    @(negedge pin_clk);
    while (cs0 && qc < 200) begin qc++; @(negedge pin_clk); end
    while (!cs0 && lc < 2000) begin lc++; @(negedge pin_clk); end
  endtask

  task automatic wait_frames0(input int target, output bit ok);
    int t;
    t = 0;
    while (frames0 < target && t < 3000) begin @(negedge pin_clk); t++; end
    ok = (frames0 >= target);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge pin_clk);
    #1 reset_n = 1'b1;
    @(negedge pin_clk);
    checks++; if (cs0 !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs0); end
    checks++; if (sclk0 !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b expected 1", sclk0); end
    checks++; if (if0.sample !== '0) begin errors++; $display("FAIL reset_sample: got %h expected 0", if0.sample); end
    checks++; if (if0.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if0.sample_valid); end
    checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", ovr0); end
    checks++; if (fe0 !== 1'b0) begin errors++; $display("FAIL reset_format_err: got %b expected 0", fe0); end
    @(posedge pin_clk); #1;
  endtask

  task automatic test_single_frame();
    int qc, lc, r0;
    logic [15:0] w;
    w = 16'h0AC3;
    word_tab0[starts0 % 64] = w;
    if0.sample_ready = 1'b0;
    r0 = rise0;
    pulse_start0();
    measure_frame0(qc, lc);
    checks++; if (qc !== QC) begin errors++; $display("FAIL single_quiet: got %0d expected %0d", qc, QC); end
    checks++; if (lc !== 2 * FB) begin errors++; $display("FAIL single_cs_low: got %0d expected %0d", lc, 2 * FB); end
    checks++; if (rise0 - r0 !== FB) begin errors++; $display("FAIL single_rises: got %0d expected %0d", rise0 - r0, FB); end
    @(posedge pin_clk); @(negedge pin_clk);
    checks++; if (if0.sample_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", if0.sample_valid); end
    checks++; if (if0.sample !== 12'hAC3) begin errors++; $display("FAIL single_sample: got %h expected ac3", if0.sample); end
    checks++; if (fe0 !== 1'b0) begin errors++; $display("FAIL single_format_err: got %b expected 0", fe0); end
    @(posedge pin_clk); #1;
    if0.sample_ready = 1'b1;
    @(posedge pin_clk); #1;
    @(negedge pin_clk);
    checks++; if (if0.sample_valid !== 1'b0) begin errors++; $display("FAIL single_consume: got %b expected 0", if0.sample_valid); end
    checks++; if (cs0 !== 1'b1) begin errors++; $display("FAIL single_idle_cs: got %b expected 1", cs0); end
    @(posedge pin_clk); #1;
  endtask

  task automatic test_random_frames();
    int qc, lc;
    logic [15:0] w;
    if0.sample_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = 16'($urandom);
      if (i % 2 == 0) w[15:12] = 4'h0;
      word_tab0[starts0 % 64] = w;
      clear_flags = 1'b1;
      pulse_start0();
      clear_flags = 1'b0;
      measure_frame0(qc, lc);
      @(posedge pin_clk); @(negedge pin_clk);
      checks++; if (if0.sample !== exp_sample(w)) begin errors++; $display("FAIL rand_sample[%0d]: got %h expected %h", i, if0.sample, exp_sample(w)); end
      checks++; if (fe0 !== exp_fmt(w)) begin errors++; $display("FAIL rand_format_err[%0d]: got %b expected %b", i, fe0, exp_fmt(w)); end
      repeat (3) @(posedge pin_clk);
      #1;
    end
    pulse_clear();
  endtask

  task automatic test_format_err();
    int qc, lc;
    logic [15:0] w;
    w = 16'h4000 | 16'($urandom_range(0, 4095));
    word_tab0[starts0 % 64] = w;
    if0.sample_ready = 1'b1;
    pulse_start0();
    measure_frame0(qc, lc);
    @(posedge pin_clk); @(negedge pin_clk);
    checks++; if (fe0 !== 1'b1) begin errors++; $display("FAIL fmt_set: got %b expected 1", fe0); end
    checks++; if (if0.sample !== exp_sample(w)) begin errors++; $display("FAIL fmt_sample: got %h expected %h", if0.sample, exp_sample(w)); end
    @(posedge pin_clk); #1;
    pulse_clear();
    @(negedge pin_clk);
    checks++; if (fe0 !== 1'b0) begin errors++; $display("FAIL fmt_clear: got %b expected 0", fe0); end
    @(posedge pin_clk); #1;
  endtask

  task automatic test_overrun();
    logic [15:0] w1, w2, w3;
    int f0, lows;
    bit ok;
    w1 = 16'($urandom) & 16'h0FFF;
    w2 = (16'($urandom) & 16'h0FFF) ^ 16'h0001;
    w3 = 16'($urandom) & 16'h0FFF;
    if (w2 == w1) w2 = w1 ^ 16'h0800;
    word_tab0[starts0 % 64] = w1;
    word_tab0[(starts0 + 1) % 64] = w2;
    word_tab0[(starts0 + 2) % 64] = w3;
    if0.sample_ready = 1'b0;
    f0 = frames0;
    enable = 1'b1;
    wait_frames0(f0 + 1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovr_frame1_timeout: got %b expected 1", ok); end
    @(posedge pin_clk); @(negedge pin_clk);
    checks++; if (if0.sample !== exp_sample(w1)) begin errors++; $display("FAIL ovr_sample1: got %h expected %h", if0.sample, exp_sample(w1)); end
    checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL ovr_after1: got %b expected 0", ovr0); end
    wait_frames0(f0 + 2, ok);
    @(posedge pin_clk); @(negedge pin_clk);
    checks++; if (ovr0 !== 1'b1) begin errors++; $display("FAIL ovr_after2: got %b expected 1", ovr0); end
    checks++; if (if0.sample !== exp_sample(w1)) begin errors++; $display("FAIL ovr_sample2: got %h expected %h", if0.sample, exp_sample(w1)); end
    @(posedge pin_clk); #1;
    enable = 1'b0;
    wait_frames0(f0 + 3, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovr_frame3_timeout: got %b expected 1", ok); end
    @(posedge pin_clk); @(negedge pin_clk);
    checks++; if (if0.sample !== exp_sample(w1)) begin errors++; $display("FAIL ovr_sample3: got %h expected %h", if0.sample, exp_sample(w1)); end
    checks++; if (if0.sample_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", if0.sample_valid); end
    lows = 0;
    for (int i = 0; i < 30; i++) begin @(negedge pin_clk); if (!cs0) lows++; end
    checks++; if (lows !== 0) begin errors++; $display("FAIL ovr_idle_after: got %0d low cycles expected 0", lows); end
    @(posedge pin_clk); #1;
    if0.sample_ready = 1'b1;
    @(posedge pin_clk); #1;
    @(negedge pin_clk);
    checks++; if (if0.sample_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %b expected 0", if0.sample_valid); end
    @(posedge pin_clk); #1;
    pulse_clear();
    @(negedge pin_clk);
    checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", ovr0); end
    @(posedge pin_clk); #1;
  endtask

  task automatic test_clkdiv3();
    logic [15:0] w;
    logic cur;
    int t, lc, run, bad, nruns;
    w = 16'($urandom) & 16'h0FFF;
    word_tab1[starts1 % 64] = w;
    if1.sample_ready = 1'b1;
    start3 = 1'b1;
    @(posedge pin_clk); #1;
    start3 = 1'b0;
    t = 0;
    @(negedge pin_clk);
    while (cs1 && t < 200) begin t++; @(negedge pin_clk); end
    checks++; if (sclk1 !== 1'b0) begin errors++; $display("FAIL div3_first_phase: got %b expected 0", sclk1); end
    lc = 0; run = 0; bad = 0; nruns = 0; cur = sclk1;
    while (!cs1 && lc < 2000) begin
      lc++;
      if (sclk1 === cur) begin
        run++;
      end else begin
        if (run != 3) bad++;
        nruns++;
        cur = sclk1;
        run = 1;
      end
      @(negedge pin_clk);
    end
    if (run != 3) bad++;
    nruns++;
    checks++; if (lc !== 96) begin errors++; $display("FAIL div3_cs_low: got %0d expected 96", lc); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL div3_phase_width: got %0d bad phases expected 0", bad); end
    checks++; if (nruns !== 2 * FB) begin errors++; $display("FAIL div3_phases: got %0d expected %0d", nruns, 2 * FB); end
    @(posedge pin_clk); @(negedge pin_clk);
    checks++; if (if1.sample !== exp_sample(w)) begin errors++; $display("FAIL div3_sample: got %h expected %h", if1.sample, exp_sample(w)); end
    @(posedge pin_clk); #1;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w, w2;
    int t, qc, lc, r0;
    w = 16'($urandom) & 16'h0FFF;
    w2 = 16'($urandom) & 16'h0FFF;
    word_tab0[starts0 % 64] = w;
    word_tab0[(starts0 + 1) % 64] = w2;
    if0.sample_ready = 1'b0;
    r0 = rise0;
    pulse_start0();
    t = 0;
    while (rise0 - r0 < 8 && t < 200) begin @(negedge pin_clk); t++; end
    checks++; if (rise0 - r0 !== 8) begin errors++; $display("FAIL rst_reach_edge8: got %0d expected 8", rise0 - r0); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (cs0 !== 1'b1) begin errors++; $display("FAIL rst_async_cs: got %b expected 1", cs0); end
    checks++; if (sclk0 !== 1'b1) begin errors++; $display("FAIL rst_async_sclk: got %b expected 1", sclk0); end
    repeat (2) @(posedge pin_clk);
    #1 reset_n = 1'b1;
    repeat (10) @(negedge pin_clk);
    checks++; if (if0.sample_valid !== 1'b0) begin errors++; $display("FAIL rst_no_sample: got %b expected 0", if0.sample_valid); end
    @(posedge pin_clk); #1;
    r0 = rise0;
    pulse_start0();
    measure_frame0(qc, lc);
    checks++; if (qc !== QC) begin errors++; $display("FAIL rst_quiet: got %0d expected %0d", qc, QC); end
    checks++; if (lc !== 2 * FB) begin errors++; $display("FAIL rst_cs_low: got %0d expected %0d", lc, 2 * FB); end
    checks++; if (rise0 - r0 !== FB) begin errors++; $display("FAIL rst_rises: got %0d expected %0d", rise0 - r0, FB); end
    @(posedge pin_clk); @(negedge pin_clk);
    checks++; if (if0.sample !== exp_sample(w2)) begin errors++; $display("FAIL rst_sample: got %h expected %h", if0.sample, exp_sample(w2)); end
    checks++; if (if0.sample_valid !== 1'b1) begin errors++; $display("FAIL rst_valid: got %b expected 1", if0.sample_valid); end
    @(posedge pin_clk); #1;
    if0.sample_ready = 1'b1;
    repeat (2) @(posedge pin_clk);
    #1;
  endtask

  task automatic test_enable_drop();
    logic [15:0] w;
    int t, f0, r0, lows;
    bit ok;
    w = 16'($urandom) & 16'h0FFF;
    word_tab0[starts0 % 64] = w;
    if0.sample_ready = 1'b1;
    f0 = frames0;
    r0 = rise0;
    enable = 1'b1;
    t = 0;
    while (rise0 - r0 < 5 && t < 200) begin @(negedge pin_clk); t++; end
    @(posedge pin_clk); #1;
    enable = 1'b0;
    wait_frames0(f0 + 1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL endrop_timeout: got %b expected 1", ok); end
    @(posedge pin_clk); @(negedge pin_clk);
    checks++; if (if0.sample !== exp_sample(w)) begin errors++; $display("FAIL endrop_sample: got %h expected %h", if0.sample, exp_sample(w)); end
    checks++; if (if0.sample_valid !== 1'b1) begin errors++; $display("FAIL endrop_valid: got %b expected 1", if0.sample_valid); end
    lows = 0;
    for (int i = 0; i < 30; i++) begin @(negedge pin_clk); if (!cs0) lows++; end
    checks++; if (lows !== 0) begin errors++; $display("FAIL endrop_idle: got %0d low cycles expected 0", lows); end
    checks++; if (frames0 - f0 !== 1) begin errors++; $display("FAIL endrop_frames: got %0d expected 1", frames0 - f0); end
    @(posedge pin_clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin word_tab0[i] = '0; word_tab1[i] = '0; end
    reset_n = 1'b0;
    enable = 1'b0;
    start = 1'b0;
    start3 = 1'b0;
    clear_flags = 1'b0;
    if0.sample_ready = 1'b0;
    if1.sample_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_random_frames();
    test_format_err();
    test_overrun();
    test_clkdiv3();
    test_reset_mid_frame();
    test_enable_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/adc_sample_reader.md
ADC_SAMPLE_READER -- requirements
Module: adc_sample_reader

Interface
REQ-001 Parameter CLK_DIV, default 1; SCLK half-period in pin_clk cycles, legal range 1..255.
REQ-002 Parameter FRAME_BITS, default 16; SCLK rising edges per conversion frame.
REQ-003 Parameter LEAD_BITS, default 4; leading bits per frame, discarded and checked for zero.
REQ-004 Parameter DATA_BITS, default 12; sample bits following the lead bits, MSB first.
REQ-005 Parameter QUIET_CYCLES, default 4; minimum pin_clk cycles with adc_cs_n high between frames.
REQ-006 Constraint: LEAD_BITS + DATA_BITS <= FRAME_BITS.
REQ-007 pin_clk  in  1  single clock for all logic (16 MHz board clock).
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 enable  in  1  level; continuous conversions while high.
REQ-010 start  in  1  one-cycle pulse; requests a single conversion.
REQ-011 adc_cs_n  out  1  ADC chip select, active low.
REQ-012 adc_sclk  out  1  ADC serial clock; idles high.
REQ-013 adc_so  in  1  ADC serial data.
REQ-014 sample  out  DATA_BITS  last captured sample.
REQ-015 sample_valid / sample_ready  out / in  1 / 1  output handshake.
REQ-016 overrun  out  1  sticky: a completed sample was dropped.
REQ-017 format_err  out  1  sticky: a lead bit was nonzero.
REQ-018 clear_flags  in  1  pulse; clears overrun and format_err.

Function
REQ-019 FSM states: IDLE, QUIET, SHIFT, DONE.
REQ-020 IDLE -> QUIET when enable=1, or when start=1 for one cycle; start while not in IDLE is ignored.
REQ-021 QUIET: adc_cs_n=1, adc_sclk=1; counts QUIET_CYCLES cycles, then -> SHIFT with adc_cs_n driven 0.
REQ-022 SHIFT: each bit = CLK_DIV cycles adc_sclk=0, then CLK_DIV cycles adc_sclk=1; adc_cs_n low for exactly 2*CLK_DIV*FRAME_BITS cycles.
REQ-023 adc_so is captured on the pin_clk edge that drives adc_sclk 0->1; bit index counts 0..FRAME_BITS-1 and does not wrap within a frame.
REQ-024 Bits 0..LEAD_BITS-1 are compared to 0; any 1 sets format_err.
REQ-025 Bits LEAD_BITS..LEAD_BITS+DATA_BITS-1 are shifted in MSB first; remaining bits are discarded.
REQ-026 After the last high phase: adc_cs_n=1 -> DONE for one cycle -> QUIET if enable=1, else IDLE.
REQ-027 In DONE, if sample_valid=0 or sample_ready=1: load sample and set sample_valid=1 on the next edge.
REQ-028 Otherwise the new sample is dropped, sample/sample_valid are held, and overrun is set.
REQ-029 sample_valid clears on the cycle after sample_valid & sample_ready, unless a load occurs in the same cycle (load wins).
REQ-030 sample is stable while sample_valid=1.
REQ-031 Deasserting enable mid-frame completes the current frame, then -> IDLE.
REQ-032 clear_flags coincident with a set condition: the set wins.

Reset
REQ-033 reset_n=0 asynchronously forces: state=IDLE, adc_cs_n=1, adc_sclk=1, sample=0, sample_valid=0, overrun=0, format_err=0, all counters=0.
REQ-034 Reset mid-frame aborts the frame with no sample delivered; the first frame after release starts with a full QUIET period.

Verification
REQ-035 Defaults, start pulse, ADC model returns 0000_1010_1100_0011 -> after 4 quiet cycles, cs_n low 32 cycles, 16 sclk rising edges, sample=0xAC3, sample_valid=1, format_err=0.
REQ-036 Lead bits 0100, sample_ready=1 -> format_err=1; clear_flags -> 0.
REQ-037 enable=1, sample_ready=0, three frames -> first sample held, overrun=1 after frame 2, sample unchanged.
REQ-038 CLK_DIV=3 -> sclk low/high 3 cycles each; cs_n low 96 cycles.
REQ-039 reset_n pulsed at sclk edge 8 -> cs_n=1 and sclk=1 immediately, sample_valid stays 0; next start yields a correct full frame.
REQ-040 enable dropped at bit 5 -> frame completes, sample delivered, FSM returns to IDLE, cs_n stays high.
